// File: rtl/tl_log_arbiter.sv
// Round-robin merge of NREQ TileLink log streams through per-requester FIFOs into one
// registered log-write port. Optional enqueue-time cycle stamping via TL_LOG_ARBITER_STAMP_EN.
module tl_log_arbiter #(
    parameter int NREQ  = 5,
    parameter int DEPTH = 2
) (
    input  logic                clock,
    input  logic                reset,
    input  logic [NREQ-1:0]     in_valid,
    output logic [NREQ-1:0]     in_ready,
    input  logic [32*NREQ-1:0]  in_meta,
    input  logic [64*NREQ-1:0]  in_address,
    input  logic [256*NREQ-1:0] in_data,
    input  logic                out_ready,
    output logic                out_wen,
    output logic [7:0]          out_channel,
    output logic [7:0]          out_opcode,
    output logic [7:0]          out_param,
    output logic [7:0]          out_source,
    output logic [7:0]          out_sink,
    output logic [63:0]         out_address,
    output logic [255:0]        out_data,
    output logic [63:0]         out_stamp
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH + 1);
    localparam int RW = (NREQ > 1) ? $clog2(NREQ) : 1;

    logic [31:0]     meta_mem [NREQ][DEPTH];
    logic [63:0]     addr_mem [NREQ][DEPTH];
    logic [255:0]    data_mem [NREQ][DEPTH];
    logic [AW-1:0]   wr_ptr_q [NREQ];
    logic [AW-1:0]   rd_ptr_q [NREQ];
    logic [CW-1:0]   count_q  [NREQ];
    logic [NREQ-1:0] push;
    logic [NREQ-1:0] pop;
    logic [NREQ-1:0] nonempty;
    logic [RW-1:0]   rr_ptr_q;
    logic [RW-1:0]   rr_ptr_d;
    logic [RW-1:0]   grant;
    logic            load;
    logic            out_wen_q;
    logic            out_wen_d;
    logic [7:0]      out_channel_q;
    logic [31:0]     out_meta_q;
    logic [63:0]     out_address_q;
    logic [255:0]    out_data_q;

    always_comb begin
        for (int i = 0; i < NREQ; i++) begin
            nonempty[i] = (count_q[i] != '0);
            in_ready[i] = (count_q[i] != CW'(DEPTH));
        end
    end

    assign push = in_valid & in_ready;

    // First non-empty FIFO at or after rr_ptr, wrapping.
    always_comb begin
        int   j;
        logic found;
        grant = '0;
        found = 1'b0;
        j     = 0;
        for (int k = 0; k < NREQ; k++) begin
            j = (int'(rr_ptr_q) + k) % NREQ;
            if (!found && nonempty[j]) begin
                grant = RW'(j);
                found = 1'b1;
            end
        end
    end

    assign load = (!out_wen_q || out_ready) && (|nonempty);

    always_comb begin
        pop = '0;
        if (load) pop[grant] = 1'b1;
        rr_ptr_d = rr_ptr_q;
        if (load) rr_ptr_d = (grant == RW'(NREQ - 1)) ? '0 : grant + RW'(1);
        out_wen_d = out_wen_q;
        if (load) out_wen_d = 1'b1;
        else if (out_wen_q && out_ready) out_wen_d = 1'b0;
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < NREQ; i++) begin
                wr_ptr_q[i] <= '0;
                rd_ptr_q[i] <= '0;
                count_q[i]  <= '0;
            end
        end else begin
            for (int i = 0; i < NREQ; i++) begin
                if (push[i]) wr_ptr_q[i] <= wr_ptr_q[i] + AW'(1);
                if (pop[i]) rd_ptr_q[i] <= rd_ptr_q[i] + AW'(1);
                count_q[i] <= count_q[i] + CW'(push[i]) - CW'(pop[i]);
            end
        end
    end

    always_ff @(posedge clock) begin
        for (int i = 0; i < NREQ; i++) begin
            if (push[i]) begin
                meta_mem[i][wr_ptr_q[i]] <= in_meta[32*i +: 32];
                addr_mem[i][wr_ptr_q[i]] <= in_address[64*i +: 64];
                data_mem[i][wr_ptr_q[i]] <= in_data[256*i +: 256];
            end
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            rr_ptr_q      <= '0;
            out_wen_q     <= 1'b0;
            out_channel_q <= '0;
            out_meta_q    <= '0;
            out_address_q <= '0;
            out_data_q    <= '0;
        end else begin
            rr_ptr_q  <= rr_ptr_d;
            out_wen_q <= out_wen_d;
            if (load) begin
                out_channel_q <= 8'(grant);
                out_meta_q    <= meta_mem[grant][rd_ptr_q[grant]];
                out_address_q <= addr_mem[grant][rd_ptr_q[grant]];
                out_data_q    <= data_mem[grant][rd_ptr_q[grant]];
            end
        end
    end

`ifdef TL_LOG_ARBITER_STAMP_EN
    logic [63:0] stamp_cnt_q;
    logic [63:0] stamp_mem [NREQ][DEPTH];
    logic [63:0] out_stamp_q;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) stamp_cnt_q <= '0;
        else       stamp_cnt_q <= stamp_cnt_q + 64'd1;
    end

    always_ff @(posedge clock) begin
        for (int i = 0; i < NREQ; i++) begin
            if (push[i]) stamp_mem[i][wr_ptr_q[i]] <= stamp_cnt_q;
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset)     out_stamp_q <= '0;
        else if (load) out_stamp_q <= stamp_mem[grant][rd_ptr_q[grant]];
    end

    assign out_stamp = out_stamp_q;
`else
    assign out_stamp = '0;
`endif

    assign out_wen     = out_wen_q;
    assign out_channel = out_channel_q;
    assign out_opcode  = out_meta_q[31:24];
    assign out_param   = out_meta_q[23:16];
    assign out_source  = out_meta_q[15:8];
    assign out_sink    = out_meta_q[7:0];
    assign out_address = out_address_q;
    assign out_data    = out_data_q;
endmodule

// File: tb/tb_tl_log_arbiter.sv
// Directed bench for tl_log_arbiter with a per-channel in-order scoreboard.
module tb_tl_log_arbiter;
    localparam int NREQ = 5;

    logic                clock;
    logic                reset;
    logic [NREQ-1:0]     in_valid;
    logic [NREQ-1:0]     in_ready;
    logic [32*NREQ-1:0]  in_meta;
    logic [64*NREQ-1:0]  in_address;
    logic [256*NREQ-1:0] in_data;
    logic                out_ready;
    logic                out_wen;
    logic [7:0]          out_channel, out_opcode, out_param, out_source, out_sink;
    logic [63:0]         out_address;
    logic [255:0]        out_data;
    logic [63:0]         out_stamp;

    tl_log_arbiter #(.NREQ(NREQ), .DEPTH(2)) dut (
        .clock(clock), .reset(reset),
        .in_valid(in_valid), .in_ready(in_ready),
        .in_meta(in_meta), .in_address(in_address), .in_data(in_data),
        .out_ready(out_ready), .out_wen(out_wen), .out_channel(out_channel),
        .out_opcode(out_opcode), .out_param(out_param), .out_source(out_source),
        .out_sink(out_sink), .out_address(out_address), .out_data(out_data),
        .out_stamp(out_stamp)
    );

    typedef struct {
        int           ch;
        logic [31:0]  meta;
        logic [63:0]  addr;
        logic [255:0] data;
        logic [63:0]  stamp;
    } rec_t;

    rec_t            sb[$];
    int              passed = 0;
    int              total  = 0;
    logic [63:0]     cyc;
    logic [NREQ-1:0] last_acc;

    initial clock = 1'b0;
    always #5 clock = ~clock;

    always @(posedge clock or posedge reset) begin
        if (reset) cyc <= '0;
        else       cyc <= cyc + 64'd1;
    end

    task automatic chk(input string tag, input logic [255:0] obs, input logic [255:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    endtask

    task automatic set_rec(input int ch, input logic [31:0] m, input logic [63:0] a, input logic [255:0] d);
        in_meta[32*ch +: 32]     = m;
        in_address[64*ch +: 64]  = a;
        in_data[256*ch +: 256]   = d;
    endtask

    task automatic rand_rec(input int ch);
        logic [255:0] d;
        for (int w = 0; w < 8; w++) d[32*w +: 32] = $urandom;
        set_rec(ch, $urandom, {$urandom, $urandom}, d);
    endtask

    // One clock: log accepted inputs, then score any output transfer.
    task automatic tick();
        logic [NREQ-1:0] acc;
        logic            xfer;
        rec_t            o, e;
        bit              hit;
        int              hidx;
        #1;
        acc  = in_valid & in_ready;
        xfer = out_wen & out_ready;
        o.ch = int'(out_channel);
        o.meta = {out_opcode, out_param, out_source, out_sink};
        o.addr = out_address;
        o.data = out_data;
        o.stamp = out_stamp;
        for (int i = 0; i < NREQ; i++) begin
            if (acc[i]) begin
                e.ch = i;
                e.meta = in_meta[32*i +: 32];
                e.addr = in_address[64*i +: 64];
                e.data = in_data[256*i +: 256];
`ifdef TL_LOG_ARBITER_STAMP_EN
                e.stamp = cyc;
`else
                e.stamp = '0;
`endif
                sb.push_back(e);
            end
        end
        @(posedge clock);
        #1;
        last_acc = acc;
        if (xfer) begin
            hit = 0;
            hidx = 0;
            foreach (sb[k]) begin
                if (!hit && sb[k].ch == o.ch) begin
                    e = sb[k];
                    hidx = k;
                    hit = 1;
                end
            end
            chk("sb_hit", 256'(hit), 256'(1));
            if (hit) begin
                chk("sb_meta", o.meta, e.meta);
                chk("sb_addr", o.addr, e.addr);
                chk("sb_data", o.data, e.data);
                chk("sb_stamp", o.stamp, e.stamp);
                sb.delete(hidx);
            end
        end
    endtask

    task automatic do_reset();
        reset = 1'b1;
        in_valid = '0;
        repeat (2) @(posedge clock);
        #1;
        reset = 1'b0;
        sb.delete();
    endtask

    task automatic drain();
        int n;
        in_valid  = '0;
        out_ready = 1'b1;
        n = 0;
        while ((out_wen || sb.size() > 0) && n < 60) begin
            tick();
            n++;
        end
        chk("drain_bound", 256'(n < 60), 256'(1));
        chk("drain_sb_empty", 256'(sb.size()), 256'(0));
    endtask

    initial begin
        in_valid = '0; in_meta = '0; in_address = '0; in_data = '0;
        out_ready = 1'b1;
        last_acc = '0;

        // Reset state
        do_reset();
        chk("rst_out_wen", 256'(out_wen), 256'(0));
        chk("rst_channel", 256'(out_channel), 256'(0));
        chk("rst_address", 256'(out_address), 256'(0));
        chk("rst_data", out_data, 256'(0));
        chk("rst_stamp", 256'(out_stamp), 256'(0));
        chk("rst_in_ready", 256'(in_ready), 256'(5'h1f));

        // Single record from requester 2 enqueued at the edge where the counter reads 5
        repeat (5) tick();
        set_rec(2, 32'h04_01_22_33, 64'h8000_1000, {8{32'hA5A5_0002}});
        in_valid[2] = 1'b1;
        tick();
        in_valid = '0;
        chk("single_accepted", 256'(last_acc[2]), 256'(1));
        chk("single_not_yet", 256'(out_wen), 256'(0));
        tick();
        chk("single_wen", 256'(out_wen), 256'(1));
        chk("single_channel", 256'(out_channel), 256'(2));
        chk("single_opcode", 256'(out_opcode), 256'(4));
        chk("single_address", 256'(out_address), 256'(64'h8000_1000));
`ifdef TL_LOG_ARBITER_STAMP_EN
        chk("single_stamp", 256'(out_stamp), 256'(5));
`else
        chk("single_stamp", 256'(out_stamp), 256'(0));
`endif
        tick();
        chk("single_wen_drop", 256'(out_wen), 256'(0));

        // All requesters streaming: round-robin one record per cycle
        do_reset();
        out_ready = 1'b1;
        in_valid  = '1;
        for (int n = 0; n < 16; n++) begin
            for (int c = 0; c < NREQ; c++) rand_rec(c);
            tick();
            if (n >= 1) begin
                chk("rr_wen", 256'(out_wen), 256'(1));
                chk("rr_channel", 256'(out_channel), 256'((n - 1) % NREQ));
            end
        end
        drain();

        // Backpressure on requester 1: three records, out_ready low for 10 cycles
        do_reset();
        out_ready = 1'b0;
        begin
            int idx;
            idx = 0;
            for (int n = 0; n < 10; n++) begin
                in_valid[1] = (idx < 3);
                set_rec(1, {8'h10 + 8'(idx), 24'h000111}, 64'h1000 + 64'(idx), {8{32'(idx) + 32'h55}});
                tick();
                if (last_acc[1]) idx++;
                if (n >= 1) chk("bp_stable_opcode", 256'(out_opcode), 256'(8'h10));
                if (n == 2) begin
                    chk("bp_accepted", 256'(idx), 256'(3));
                    chk("bp_in_ready_low", 256'(in_ready[1]), 256'(0));
                end
            end
        end
        chk("bp_wen_held", 256'(out_wen), 256'(1));
        drain();

        // rr_ptr=1 with requesters 0 and 3 pending: grant 3 then 0
        do_reset();
        out_ready = 1'b0;
        set_rec(0, 32'h0A000000, 64'h100, '0);
        in_valid[0] = 1'b1;
        tick();
        in_valid = '0;
        tick();
        chk("rr1_first_channel", 256'(out_channel), 256'(0));
        set_rec(0, 32'h0B000000, 64'h200, '1);
        set_rec(3, 32'h0C000000, 64'h300, '1);
        in_valid[0] = 1'b1;
        in_valid[3] = 1'b1;
        tick();
        in_valid = '0;
        out_ready = 1'b1;
        tick();
        chk("rr1_grant3", 256'(out_channel), 256'(3));
        tick();
        chk("rr1_grant0", 256'(out_channel), 256'(0));
        tick();
        chk("rr1_done", 256'(out_wen), 256'(0));
        chk("rr1_sb_empty", 256'(sb.size()), 256'(0));

        // Reset mid-operation with records queued and output valid
        do_reset();
        out_ready = 1'b0;
        in_valid  = '1;
        for (int n = 0; n < 3; n++) begin
            for (int c = 0; c < NREQ; c++) rand_rec(c);
            tick();
        end
        chk("midrst_pre_wen", 256'(out_wen), 256'(1));
        #2;
        reset = 1'b1;
        #1;
        chk("midrst_wen", 256'(out_wen), 256'(0));
        chk("midrst_channel", 256'(out_channel), 256'(0));
        chk("midrst_address", 256'(out_address), 256'(0));
        chk("midrst_data", out_data, 256'(0));
        sb.delete();
        in_valid = '0;
        @(posedge clock);
        #1;
        reset = 1'b0;
        out_ready = 1'b1;
        chk("midrst_in_ready", 256'(in_ready), 256'(5'h1f));
        for (int n = 0; n < 5; n++) begin
            tick();
            chk("midrst_no_output", 256'(out_wen), 256'(0));
        end

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
